pe_ws_dbuf: RTL
===============

PE_WS_DBUF -- requirements
Module: pe_ws_dbuf

Interface
- REQ-001 SHALL have parameter WORD_WIDTH, default 8, operand and weight width in bits (signed two's complement).
- REQ-002 SHALL have parameter ACC_WIDTH, default 4*WORD_WIDTH, partial-sum width (signed).
- REQ-003 SHALL have parameter SATURATE, default 0; 0 = wrap-around accumulation, 1 = signed saturation.
- REQ-004 SHALL have parameter COUNT_WIDTH, default 16, MAC counter width.
- REQ-005 clk  in  1  single clock; all state updates on rising edge.
- REQ-006 reset  in  1  asynchronous, active-high reset.
- REQ-007 control  in  2  00 IDLE, 01 SWAP, 10 COMPUTE, 11 COMPUTE_SWAP.
- REQ-008 a_in, a_valid_in  in  WORD_WIDTH, 1  activation and its valid flag from the left neighbour.
- REQ-009 d_in, d_valid_in  in  ACC_WIDTH, 1  partial sum and its valid flag from the upper neighbour.
- REQ-010 w_in, w_load_in  in  WORD_WIDTH, 1  weight shift-chain data and load strobe.
- REQ-011 control_out_r, control_out_b  out  2, 2  control forwarded right and down.
- REQ-012 a_out, a_valid_out  out  WORD_WIDTH, 1  registered activation to the right.
- REQ-013 d_out, d_valid_out  out  ACC_WIDTH, 1  registered partial sum downward.
- REQ-014 w_out, w_load_out  out  WORD_WIDTH, 1  weight shift-chain output downward.
- REQ-015 swap_err  out  1  sticky: SWAP requested with no pending shadow weight.
- REQ-016 mac_count  out  COUNT_WIDTH  number of valid MACs performed since reset.

Function
- REQ-017 control_out_r and control_out_b SHALL equal control delayed by exactly one cycle.
- REQ-018 Weight chain: when w_load_in=1, shadow <= w_in, w_out <= old shadow, shadow_valid <= 1; w_load_out SHALL be w_load_in delayed one cycle, regardless of control.
- REQ-019 SWAP (01 or 11) with shadow_valid=1: active <= shadow, active_valid <= 1, shadow_valid <= 0 at the same edge.
- REQ-020 SWAP with shadow_valid=0: active unchanged, swap_err <= 1 (held until reset).
- REQ-021 Simultaneous w_load_in and SWAP: active takes the pre-edge shadow; shadow takes w_in; shadow_valid stays 1.
- REQ-022 COMPUTE (10 or 11): a_out <= a_in, a_valid_out <= a_valid_in each cycle.
- REQ-023 COMPUTE with a_valid_in=1 and d_valid_in=1: d_out <= d_in + sext(a_in)*sext(active) (active = pre-edge value, also under 11); d_valid_out <= 1; latency one cycle.
- REQ-024 COMPUTE with active_valid=0: product treated as 0 (d_out <= d_in passthrough, still counted valid).
- REQ-025 COMPUTE with either valid input low: d_valid_out <= 0, d_out holds.
- REQ-026 IDLE or SWAP: a_valid_out <= 0, d_valid_out <= 0, a_out/d_out hold.
- REQ-027 SATURATE=0: sum wraps modulo 2^ACC_WIDTH; SATURATE=1: clamp to [-2^(ACC_WIDTH-1), 2^(ACC_WIDTH-1)-1].
- REQ-028 mac_count SHALL increment on each cycle with d_valid_out set by REQ-023/024; it saturates at all-ones.

Reset
- REQ-029 While reset=1 every output, shadow, active, shadow_valid, active_valid and mac_count SHALL be 0, taking effect immediately without a clock edge.
- REQ-030 Reset asserted mid-compute SHALL discard the in-flight result; first valid d_out after release requires new load+swap.

Verification
- REQ-031 Assert reset between edges -> all outputs 0 before next rising edge.
- REQ-032 w_load 3 then 5 on consecutive cycles -> w_out 0 then 3; one SWAP in the next cycle (shadow=5), then COMPUTE a=2,d=4 -> d_out=14, d_valid_out=1, mac_count=1 one cycle later.
- REQ-033 active=0xFD (-3), a=7, d=0 -> d_out=0xFFFFFFEB (-21).
- REQ-034 active=127, a=127, d_in=0x7FFFFFF0 -> d_out=0x80003EF1 with SATURATE=0; 0x7FFFFFFF with SATURATE=1.
- REQ-035 SWAP after reset with no load -> swap_err=1, COMPUTE a=9,d=6 -> d_out=6; w_load 4 with simultaneous SWAP -> active keeps old shadow, next SWAP gives 4.

Source files
------------

// File: rtl/pe_ws_dbuf.sv
// Weight-stationary systolic PE with a double-buffered (shadow/active) weight.
// Shadow fills from a daisy chain while the active weight drives the MAC.
module pe_ws_dbuf #(
  parameter int WORD_WIDTH  = 8,
  parameter int ACC_WIDTH   = 4 * WORD_WIDTH,
  parameter int SATURATE    = 0,
  parameter int COUNT_WIDTH = 16
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic [1:0]             control,
  input  logic [WORD_WIDTH-1:0]  a_in,
  input  logic                   a_valid_in,
  input  logic [ACC_WIDTH-1:0]   d_in,
  input  logic                   d_valid_in,
  input  logic [WORD_WIDTH-1:0]  w_in,
  input  logic                   w_load_in,
  output logic [1:0]             control_out_r,
  output logic [1:0]             control_out_b,
  output logic [WORD_WIDTH-1:0]  a_out,
  output logic                   a_valid_out,
  output logic [ACC_WIDTH-1:0]   d_out,
  output logic                   d_valid_out,
  output logic [WORD_WIDTH-1:0]  w_out,
  output logic                   w_load_out,
  output logic                   swap_err,
  output logic [COUNT_WIDTH-1:0] mac_count
);

  typedef enum logic [1:0] {
    CTL_IDLE         = 2'b00,
    CTL_SWAP         = 2'b01,
    CTL_COMPUTE      = 2'b10,
    CTL_COMPUTE_SWAP = 2'b11
  } ctl_e;

  ctl_e ctl;

  logic [WORD_WIDTH-1:0]          shadow;
  logic [WORD_WIDTH-1:0]          active;
  logic                           shadow_valid;
  logic                           active_valid;

  logic                           swap_req;
  logic                           compute_req;
  logic                           mac_fire;
  logic signed [2*WORD_WIDTH-1:0] product;
  logic signed [ACC_WIDTH:0]      sum_ext;
  logic                           overflow;
  logic [ACC_WIDTH-1:0]           sum_acc;

  assign ctl = ctl_e'(control);

  always_comb begin
    swap_req    = (ctl == CTL_SWAP)    || (ctl == CTL_COMPUTE_SWAP);
    compute_req = (ctl == CTL_COMPUTE) || (ctl == CTL_COMPUTE_SWAP);
    mac_fire    = compute_req && a_valid_in && d_valid_in;

    // if/else rather than ?: so the '0 arm cannot make the multiply unsigned
    product = '0;
    if (active_valid) begin
      product = $signed(a_in) * $signed(active);
    end

    // One guard bit above the accumulator exposes signed overflow
    sum_ext  = (ACC_WIDTH+1)'($signed(d_in)) + (ACC_WIDTH+1)'(product);
    overflow = sum_ext[ACC_WIDTH] ^ sum_ext[ACC_WIDTH-1];

    sum_acc = sum_ext[ACC_WIDTH-1:0];
    if ((SATURATE != 0) && overflow) begin
      sum_acc = sum_ext[ACC_WIDTH] ? {1'b1, {(ACC_WIDTH-1){1'b0}}}
                                   : {1'b0, {(ACC_WIDTH-1){1'b1}}};
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      control_out_r <= '0;
      control_out_b <= '0;
      a_out         <= '0;
      a_valid_out   <= 1'b0;
      d_out         <= '0;
      d_valid_out   <= 1'b0;
      w_out         <= '0;
      w_load_out    <= 1'b0;
      swap_err      <= 1'b0;
      mac_count     <= '0;
      shadow        <= '0;
      active        <= '0;
      shadow_valid  <= 1'b0;
      active_valid  <= 1'b0;
    end else begin
      control_out_r <= control;
      control_out_b <= control;
      w_load_out    <= w_load_in;

      if (w_load_in) begin
        shadow <= w_in;
        w_out  <= shadow;
      end

      if (swap_req) begin
        if (shadow_valid) begin
          active       <= shadow;
          active_valid <= 1'b1;
        end else begin
          swap_err <= 1'b1;
        end
      end

      // A load in the same cycle as a swap refills the shadow, so it stays valid
      shadow_valid <= w_load_in | (shadow_valid & ~swap_req);

      if (compute_req) begin
        a_out       <= a_in;
        a_valid_out <= a_valid_in;
        d_valid_out <= mac_fire;
        if (mac_fire) begin
          d_out <= sum_acc;
        end
      end else begin
        a_valid_out <= 1'b0;
        d_valid_out <= 1'b0;
      end

      if (mac_fire && (mac_count != '1)) begin
        mac_count <= mac_count + COUNT_WIDTH'(1);
      end
    end
  end

endmodule
